pixel_write_scheduler: RTL

Sequences pixel writes into `graphic_manager`, sharing its single pixel-write port between two requesters: the touch/drawing path (single pixels, valid/ready) and a full-screen clear engine (rectangle fill in row-major order). It holds off all traffic until the display reports `initialized`. It paces every `write_pixel` pulse so `graphic_manager` is never re-triggered before its TFT transfer completes.

---
 rtl/pixel_write_scheduler_pkg.sv | 29 ++
 rtl/pixel_write_scheduler_raster_counter.sv | 52 +++++
 rtl/pixel_write_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pixel_write_scheduler_pkg.sv
// Shared display constants and scheduler state encoding for the pixel-write path.
package pixel_write_scheduler_pkg;

  // Panel resolution shared with graphic_manager and the touch path
  localparam int DISP_H_RES = 320;
  localparam int DISP_V_RES = 240;

  // Coordinate bus widths at the graphic_manager pixel port
  localparam int COL_W = 9;
  localparam int ROW_W = 8;

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    IDLE      = 3'd1,
    ISSUE     = 3'd2,
    GAP       = 3'd3,
    CLR_ISSUE = 3'd4,
    CLR_GAP   = 3'd5
  } sched_state_t;

  // True when (col,row) lies on a display of the given resolution
  function automatic logic coord_in_range(input logic [COL_W-1:0] col,
                                          input logic [ROW_W-1:0] row,
                                          input int               h_res,
                                          input int               v_res);
    return (int'(col) < h_res) && (int'(row) < v_res);
  endfunction

endpackage

// File: rtl/pixel_write_scheduler_raster_counter.sv
// Row-major col/row scan counter with wrap and last-pixel flag.
module pixel_write_scheduler_raster_counter
  import pixel_write_scheduler_pkg::*;
#(
  parameter int H_RES = DISP_H_RES,
  parameter int V_RES = DISP_V_RES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             zero,
  input  logic             step,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_RES - 1);

  logic             col_wrap;
  logic [COL_W-1:0] col_n;
  logic [ROW_W-1:0] row_n;

  // Next scan position: column wraps into the next row, last pixel wraps to origin
  always_comb begin
    col_wrap = (col == COL_MAX);
    last     = col_wrap && (row == ROW_MAX);
    col_n    = col_wrap ? '0 : col + COL_W'(1);
    row_n    = row;
    if (col_wrap) begin
      row_n = (row == ROW_MAX) ? '0 : row + ROW_W'(1);
    end
  end

  // Position register: zero restarts the scan, step advances one pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (zero) begin
        col <= '0;
        row <= '0;
      end else if (step) begin
        col <= col_n;
        row <= row_n;
      end
    end
  end

endmodule

// File: rtl/pixel_write_scheduler.sv
// Arbitrates touch draws and full-screen clears onto the single graphic_manager
// pixel-write port, pacing strobes so the TFT transfer always finishes first.
module pixel_write_scheduler
  import pixel_write_scheduler_pkg::*;
#(
  parameter int H_RES      = DISP_H_RES,
  parameter int V_RES      = DISP_V_RES,
  parameter int GAP_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             initialized,
  input  logic             touch_valid,
  output logic             touch_ready,
  input  logic [COL_W-1:0] touch_col,
  input  logic [ROW_W-1:0] touch_row,
  input  logic             touch_color,
  input  logic             clear_req,
  input  logic             clear_color,
  output logic             clear_busy,
  output logic             clear_done,
  output logic             write_pixel,
  output logic [COL_W-1:0] pixel_col,
  output logic [ROW_W-1:0] pixel_row,
  output logic             bw_pixel_color
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  sched_state_t     state;
  sched_state_t     state_n;
  logic [GAP_W-1:0] gap_cnt;
  logic             touch_ok;
  logic             load_touch;
  logic             load_scan;
  logic             rc_zero;
  logic             rc_step;
  logic             last_issued;
  logic [COL_W-1:0] scan_col;
  logic [ROW_W-1:0] scan_row;
  logic             scan_last;

  assign touch_ok   = coord_in_range(touch_col, touch_row, H_RES, V_RES);
  assign clear_busy = (state == CLR_ISSUE) || (state == CLR_GAP);

  // The scan counter advances as each clear pixel is strobed, so it already
  // holds the next coordinate when the gap expires.
  pixel_write_scheduler_raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_raster (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .zero  (rc_zero),
    .step  (rc_step),
    .col   (scan_col),
    .row   (scan_row),
    .last  (scan_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_INIT;
    end else begin
      state <= state_n;
    end
  end

  // Next state and strobes; every action is gated by en so a low en freezes the scheduler
  always_comb begin
    state_n     = state;
    touch_ready = 1'b0;
    write_pixel = 1'b0;
    clear_done  = 1'b0;
    load_touch  = 1'b0;
    load_scan   = 1'b0;
    rc_zero     = 1'b0;
    rc_step     = 1'b0;
    case (state)
      WAIT_INIT: begin
        if (en && initialized) begin
          state_n = IDLE;
        end
      end
      IDLE: begin
        touch_ready = en && !clear_req;
        if (en && clear_req) begin
          rc_zero = 1'b1;
          state_n = CLR_ISSUE;
        end else if (en && touch_valid && touch_ok) begin
          // out-of-range touches complete the handshake but stay here
          load_touch = 1'b1;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        write_pixel = en;
        if (en) begin
          state_n = GAP;
        end
      end
      GAP: begin
        if (en && (gap_cnt == '0)) begin
          state_n = IDLE;
        end
      end
      CLR_ISSUE: begin
        write_pixel = en;
        if (en) begin
          rc_step = 1'b1;
          state_n = CLR_GAP;
        end
      end
      CLR_GAP: begin
        if (en && (gap_cnt == '0)) begin
          if (last_issued) begin
            clear_done = 1'b1;
            state_n    = IDLE;
          end else begin
            load_scan = 1'b1;
            state_n   = CLR_ISSUE;
          end
        end
      end
      default: begin
        state_n = WAIT_INIT;
      end
    endcase
  end

  // Gap counter: loaded on every strobe, counts down to zero through the gap
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (en) begin
      if ((state == ISSUE) || (state == CLR_ISSUE)) begin
        gap_cnt <= GAP_LOAD;
      end else if (((state == GAP) || (state == CLR_GAP)) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  // Pixel output registers, loaded one edge ahead of the strobe they accompany
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_col      <= '0;
      pixel_row      <= '0;
      bw_pixel_color <= 1'b0;
      last_issued    <= 1'b0;
    end else if (load_touch) begin
      pixel_col      <= touch_col;
      pixel_row      <= touch_row;
      bw_pixel_color <= touch_color;
    end else if (rc_zero) begin
      pixel_col      <= '0;
      pixel_row      <= '0;
      bw_pixel_color <= clear_color;
      last_issued    <= 1'b0;
    end else if (rc_step) begin
      last_issued <= scan_last;
    end else if (load_scan) begin
      pixel_col <= scan_col;
      pixel_row <= scan_row;
    end
  end

endmodule
